// File: rtl/fifo_cfg_pkg.sv
// fifo_cfg_pkg: shared parameter defaults and controller state encodings for
// the segmented FIFO. The states are plain 2-bit constants so the package can
// also be consumed by older tools that do not handle typedef enums well.
//   DEF_DATA_WIDTH  default word width
//   DEF_SEG_DEPTH   default words per segment (power of two)
//   DEF_NUM_SEGS    default maximum number of segments
//   E_SIN_CONFIG    no capacity applied yet; traffic ignored
//   E_OPERANDO      normal push/pop operation
//   E_DRENANDO      draining before a pending capacity change
package fifo_cfg_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_SEG_DEPTH  = 4;
    localparam int DEF_NUM_SEGS   = 4;

    localparam logic [1:0] E_SIN_CONFIG = 2'd0;
    localparam logic [1:0] E_OPERANDO   = 2'd1;
    localparam logic [1:0] E_DRENANDO   = 2'd2;

endpackage

// File: rtl/mem_dual_puerto.sv
// mem_dual_puerto: register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
module mem_dual_puerto #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_segmentos_param.sv
// fifo_segmentos_param: FIFO whose capacity is a run-time selectable number of
// fixed-size segments. A capacity change on a non-empty FIFO is held pending
// while the FIFO drains, then applied with pointers cleared.
//   clk, reset          clock, asynchronous active-high reset
//   push, data_in       write request and data
//   pop                 read request
//   save_config         capture configuration (segment count) this cycle
//   configuration       requested segment count, valid 1..NUM_SEGS
//   data_out/data_valid registered read data and its one-cycle strobe
//   fill_count          stored words
//   buffer_full/empty   fill_count == capacity / fill_count == 0
//   no_config           no capacity applied yet
//   reconfig_pending    draining towards a pending capacity
//   overflow_err        sticky: a push was rejected
//   underflow_err       sticky: a pop was rejected
module fifo_segmentos_param
    import fifo_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SEG_DEPTH  = DEF_SEG_DEPTH,
    parameter int NUM_SEGS   = DEF_NUM_SEGS,
    localparam int CW = $clog2(NUM_SEGS + 1),
    localparam int NW = $clog2(NUM_SEGS * SEG_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  save_config,
    input  logic [CW-1:0]         configuration,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [NW-1:0]         fill_count,
    output logic                  buffer_full,
    output logic                  buffer_empty,
    output logic                  no_config,
    output logic                  reconfig_pending,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int DEPTH = NUM_SEGS * SEG_DEPTH;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]            state_q, state_d;
    logic [NW-1:0]         cap_q, cap_d;
    logic [CW-1:0]         pend_q, pend_d;
    logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, rd_data;
    logic                  dv_q, dv_d, ovf_q, ovf_d, udf_q, udf_d;

    logic          cfg_ok, operating, push_ok, pop_ok, do_push, do_pop;
    logic          push_rej, pop_rej, apply;
    logic [CW-1:0] apply_cfg;
    logic [AW-1:0] next_wr, next_rd;

    assign cfg_ok    = save_config && configuration != '0 && configuration <= CW'(NUM_SEGS);
    assign operating = state_q != E_SIN_CONFIG;
    // Push/pop are judged against the pre-edge count, independently of each other.
    assign push_ok   = state_q == E_OPERANDO && cnt_q < cap_q;
    assign pop_ok    = operating && cnt_q != '0;
    assign do_push   = push && push_ok;
    assign do_pop    = pop && pop_ok;
    // Traffic before the first configuration is silently ignored (no flags).
    assign push_rej  = push && operating && !push_ok;
    assign pop_rej   = pop && operating && !pop_ok;
    // A capacity is applied on the first config, on a config while empty, or
    // once the drain completes; a config arriving that same cycle wins.
    assign apply     = (state_q == E_SIN_CONFIG && cfg_ok)
                    || (state_q == E_OPERANDO && cfg_ok && cnt_q == '0)
                    || (state_q == E_DRENANDO && cnt_q == '0);
    assign apply_cfg = cfg_ok ? configuration : pend_q;
    assign next_wr   = (NW'(wr_q) == cap_q - NW'(1)) ? '0 : wr_q + AW'(1);
    assign next_rd   = (NW'(rd_q) == cap_q - NW'(1)) ? '0 : rd_q + AW'(1);

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (apply) begin
            state_d = E_OPERANDO;
            cap_d   = NW'(apply_cfg) * NW'(SEG_DEPTH);
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (do_push) wr_d = next_wr;
            if (do_pop) begin
                rd_d   = next_rd;
                dout_d = rd_data;
                dv_d   = 1'b1;
            end
            cnt_d = cnt_q + NW'(do_push) - NW'(do_pop);
            ovf_d = ovf_q | push_rej;
            udf_d = udf_q | pop_rej;
            // Non-empty when configured here: hold the value and drain first.
            if (cfg_ok && operating) begin
                pend_d  = configuration;
                state_d = E_DRENANDO;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= E_SIN_CONFIG;
            cap_q   <= '0;
            pend_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    mem_dual_puerto #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk  (clk),
        .we   (do_push && !apply),
        .waddr(wr_q),
        .wdata(data_in),
        .raddr(rd_q),
        .rdata(rd_data)
    );

    assign data_out         = dout_q;
    assign data_valid       = dv_q;
    assign fill_count       = cnt_q;
    assign buffer_full      = operating && cnt_q == cap_q;
    assign buffer_empty     = cnt_q == '0;
    assign no_config        = state_q == E_SIN_CONFIG;
    assign reconfig_pending = state_q == E_DRENANDO;
    assign overflow_err     = ovf_q;
    assign underflow_err    = udf_q;

endmodule
